// File: rtl/sbus_arbiter.sv
// -----------------------------------------------------------------------------
// sbus_arbiter
//   Shares one sbus slave between N_MASTERS bus masters (I-fetch, D-access,
//   cache refill, uncached MMIO, ...). Arbitration is either round-robin or
//   fixed priority (lowest index wins). The winner is decoded combinationally,
//   so a granted master reaches the slave in the same cycle it raises en.
//   Once a granted transfer stalls, the grant is locked to that master until
//   the transfer completes (en & !stall) or the master drops en (abort).
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   m_en_i[N]           per-master request
//   m_we_i[N]           per-master write enable
//   m_size_i[2N]        per-master size, slice [2i+:2]
//   m_addr_i[32N]       per-master address, slice [32i+:32]
//   m_data_w_i[32N]     per-master write data, slice [32i+:32]
//   m_data_r_o[32N]     read data, every slice carries s_data_r_i
//   m_stall_o[N]        per-master stall (winner sees slave stall, losers wait)
//   s_en_o .. s_data_w_o  request fields of the selected master to the slave
//   s_data_r_i, s_stall_i  slave response
//   grant_valid_o       a master drives the slave this cycle
//   grant_id_o          index of that master
//
// State table
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no owner; winner picked from m_en_i this cycle
//   ST_BUSY | owner_q holds the master whose stalled transfer is in flight
// -----------------------------------------------------------------------------
module sbus_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int FIXED_PRIO = 0,
    parameter int ID_W       = $clog2(N_MASTERS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_MASTERS-1:0]    m_en_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [2*N_MASTERS-1:0]  m_size_i,
    input  logic [32*N_MASTERS-1:0] m_addr_i,
    input  logic [32*N_MASTERS-1:0] m_data_w_i,
    output logic [32*N_MASTERS-1:0] m_data_r_o,
    output logic [N_MASTERS-1:0]    m_stall_o,
    output logic                    s_en_o,
    output logic                    s_we_o,
    output logic [1:0]              s_size_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_data_w_o,
    input  logic [31:0]             s_data_r_i,
    input  logic                    s_stall_i,
    output logic                    grant_valid_o,
    output logic [ID_W-1:0]         grant_id_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_MASTERS - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     last_q, last_d;

    logic [N_MASTERS-1:0] arb_req;
    logic [ID_W-1:0]      start_id;
    logic [ID_W-1:0]      cand_id;
    logic                 arb_found;
    logic [ID_W-1:0]      arb_id;
    logic                 hold;
    logic                 grant_valid;
    logic [ID_W-1:0]      sel_id;

    // The owner keeps the grant only while it still requests; if it drops en
    // the cycle is re-arbitrated among the others.
    assign hold = (state_q == ST_BUSY) && m_en_i[owner_q];

    // Search from start_id upwards. The wrap is an explicit compare against
    // the last index so that non-power-of-two N never lands on a phantom id.
    always_comb begin
        arb_req = m_en_i;
        if (state_q == ST_BUSY) begin
            arb_req[owner_q] = 1'b0;
        end

        if (FIXED_PRIO != 0) begin
            start_id = '0;
        end else if (last_q == LAST_ID) begin
            start_id = '0;
        end else begin
            start_id = last_q + 1'b1;
        end

        arb_found = 1'b0;
        arb_id    = '0;
        cand_id   = start_id;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!arb_found && arb_req[cand_id]) begin
                arb_found = 1'b1;
                arb_id    = cand_id;
            end
            cand_id = (cand_id == LAST_ID) ? '0 : cand_id + 1'b1;
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        sel_id      = '0;
        if (rst_i) begin
            grant_valid = 1'b0;
            sel_id      = '0;
        end else if (hold) begin
            grant_valid = 1'b1;
            sel_id      = owner_q;
        end else begin
            grant_valid = arb_found;
            sel_id      = arb_id;
        end
    end

    // Slave-side mux; all request fields read as zero when nobody is granted.
    always_comb begin
        grant_valid_o = grant_valid;
        grant_id_o    = sel_id;
        s_en_o        = grant_valid;
        s_we_o        = 1'b0;
        s_size_o      = '0;
        s_addr_o      = '0;
        s_data_w_o    = '0;
        if (grant_valid) begin
            s_we_o     = m_we_i[sel_id];
            s_size_o   = m_size_i[{sel_id, 1'b0} +: 2];
            s_addr_o   = m_addr_i[{sel_id, 5'b0} +: 32];
            s_data_w_o = m_data_w_i[{sel_id, 5'b0} +: 32];
        end
    end

    // Every requester that is not the selected master waits.
    always_comb begin
        m_stall_o = m_en_i;
        if (grant_valid) begin
            m_stall_o[sel_id] = s_stall_i;
        end
    end

    assign m_data_r_o = {N_MASTERS{s_data_r_i}};

    // A stalled grant locks the selected master; a completing grant returns
    // to IDLE and moves the round-robin pointer. An abort with no other
    // requester simply falls back to IDLE and leaves the pointer alone.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (grant_valid) begin
            if (s_stall_i) begin
                state_d = ST_BUSY;
                owner_d = sel_id;
            end else begin
                state_d = ST_IDLE;
                last_d  = sel_id;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Reset points last at N-1 so that master 0 is first in line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_ID;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule
